// File: rtl/nram_read_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : nram_read_seq_if
//  Description : Bus bundle between a read sequencer and its environment.
//                The environment holds the 2-entry storage stage and the
//                stream consumer.
//                  io_start/io_len/io_first : burst request (len 0 = 16)
//                  io_RADD / io_Q           : storage read address / data
//                  io_out_valid/ready/bits/last : output word stream
//                  io_busy / io_done / io_sum   : status and running sum
//                Modports:
//                  slave  - the sequencer side
//                  master - the environment side
//  Revision    : 1.0 - initial release
// ============================================================================
interface nram_read_seq_if #(
    parameter int W = 8
);
    logic         io_start;
    logic [3:0]   io_len;
    logic         io_first;
    logic         io_RADD;
    logic [W-1:0] io_Q;
    logic         io_out_valid;
    logic         io_out_ready;
    logic [W-1:0] io_out_bits;
    logic         io_out_last;
    logic         io_busy;
    logic         io_done;
    logic [W-1:0] io_sum;

    modport slave (
        input  io_start, io_len, io_first, io_Q, io_out_ready,
        output io_RADD, io_out_valid, io_out_bits, io_out_last,
               io_busy, io_done, io_sum
    );

    modport master (
        output io_start, io_len, io_first, io_Q, io_out_ready,
        input  io_RADD, io_out_valid, io_out_bits, io_out_last,
               io_busy, io_done, io_sum
    );
endinterface
`default_nettype wire

// File: rtl/nram_read_seq.sv
`default_nettype none
// ============================================================================
//  Module      : nram_read_seq
//  Description : Read-burst sequencer for a 2-entry storage stage. On a
//                start request it reads io_len words (0 = 16), alternating
//                the read address each word. Each word is presented on a
//                valid/ready stream, and the accepted words are summed
//                modulo 2^W.
//  Ports       : clk   - clock, rising edge
//                reset - asynchronous reset, active low
//                bus   - nram_read_seq_if.slave (request, storage read port,
//                        output stream, status)
//  Parameters  : W        - data width
//                READ_LAT - storage read latency, 0 or 1 cycles
//  Revision    : 1.0 - initial release
// ============================================================================
module nram_read_seq #(
    parameter int W        = 8,
    parameter int READ_LAT = 1
) (
    input  wire logic        clk,
    input  wire logic        reset,
    nram_read_seq_if.slave   bus
);

    localparam bit c_ZERO_LAT = (READ_LAT == 0);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_WAIT = 3'd2,
        S_OUT  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t       r_state, w_state_nxt;
    logic [4:0]   r_count, w_count_nxt;   // remaining words, up to 16
    logic         r_addr,  w_addr_nxt;
    logic [W-1:0] r_bits,  w_bits_nxt;
    logic [W-1:0] r_sum,   w_sum_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_count <= 5'd0;
            r_addr  <= 1'b0;
            r_bits  <= '0;
            r_sum   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_addr  <= w_addr_nxt;
            r_bits  <= w_bits_nxt;
            r_sum   <= w_sum_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_addr_nxt  = r_addr;
        w_bits_nxt  = r_bits;
        w_sum_nxt   = r_sum;
        case (r_state)
            S_IDLE: begin
                if (bus.io_start) begin
                    w_count_nxt = (bus.io_len == 4'd0) ? 5'd16 : {1'b0, bus.io_len};
                    w_addr_nxt  = bus.io_first;
                    w_sum_nxt   = '0;
                    w_state_nxt = S_ADDR;
                end
            end
            S_ADDR: begin
                // Address has been on io_RADD since entering ADDR; with a
                // combinational storage read the data is already valid.
                if (c_ZERO_LAT) begin
                    w_bits_nxt  = bus.io_Q;
                    w_state_nxt = S_OUT;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                w_bits_nxt  = bus.io_Q;
                w_state_nxt = S_OUT;
            end
            S_OUT: begin
                if (bus.io_out_ready) begin
                    w_sum_nxt   = r_sum + r_bits;
                    w_count_nxt = r_count - 5'd1;
                    w_addr_nxt  = ~r_addr;
                    w_state_nxt = (r_count == 5'd1) ? S_DONE : S_ADDR;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.io_RADD      = r_addr;
    assign bus.io_out_valid = (r_state == S_OUT);
    assign bus.io_out_bits  = r_bits;
    assign bus.io_out_last  = (r_state == S_OUT) && (r_count == 5'd1);
    assign bus.io_busy      = (r_state != S_IDLE);
    assign bus.io_done      = (r_state == S_DONE);
    assign bus.io_sum       = r_sum;

endmodule
`default_nettype wire

// File: tb/tb_nram_read_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nram_read_seq
//  Description : Directed self-checking bench for nram_read_seq. One
//                instance uses a registered storage model (READ_LAT=1) and
//                a second uses a combinational one (READ_LAT=0).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nram_read_seq;

    localparam int W = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    nram_read_seq_if #(.W(W)) bus  ();
    nram_read_seq_if #(.W(W)) bus0 ();

    nram_read_seq #(.W(W), .READ_LAT(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    nram_read_seq #(.W(W), .READ_LAT(0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    // Two-entry storage stage shared by both instances
    logic [W-1:0] mem [2];
    always @(posedge clk) bus.io_Q <= mem[bus.io_RADD];
    assign bus0.io_Q = mem[bus0.io_RADD];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_burst(input logic [3:0] len, input logic first);
        @(negedge clk);
        bus.io_start = 1'b1;
        bus.io_len   = len;
        bus.io_first = first;
        @(negedge clk);
        bus.io_start = 1'b0;
    endtask

    // Waits for the next presented word, checking spacing and contents
    task automatic word(input string tag, input logic [7:0] eb, input logic el,
                        input logic er, input int egap);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.io_out_valid && n < 20);
        chk({tag, " gap"},  n, egap);
        chk({tag, " bits"}, bus.io_out_bits, eb);
        chk({tag, " last"}, bus.io_out_last, el);
        chk({tag, " radd"}, bus.io_RADD, er);
    endtask

    task automatic finish_burst(input string tag, input logic [7:0] esum);
        @(negedge clk);
        chk({tag, " done"}, bus.io_done, 1'b1);
        chk({tag, " sum"},  bus.io_sum, esum);
        chk({tag, " busy_in_done"}, bus.io_busy, 1'b1);
        @(negedge clk);
        chk({tag, " done_clear"}, bus.io_done, 1'b0);
        chk({tag, " busy_clear"}, bus.io_busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset             = 1'b0;
        bus.io_start      = 1'b0;
        bus.io_len        = 4'd0;
        bus.io_first      = 1'b0;
        bus.io_out_ready  = 1'b1;
        bus0.io_start     = 1'b0;
        bus0.io_len       = 4'd0;
        bus0.io_first     = 1'b0;
        bus0.io_out_ready = 1'b1;
        mem[0] = 8'h11;
        mem[1] = 8'h22;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst busy",  bus.io_busy, 1'b0);
        chk("rst valid", bus.io_out_valid, 1'b0);
        chk("rst bits",  bus.io_out_bits, 8'h00);
        chk("rst last",  bus.io_out_last, 1'b0);
        chk("rst done",  bus.io_done, 1'b0);
        chk("rst sum",   bus.io_sum, 8'h00);
        chk("rst radd",  bus.io_RADD, 1'b0);
        reset = 1'b1;

        // len=4, first=0
        start_burst(4'd4, 1'b0);
        word("b1w1", 8'h11, 1'b0, 1'b0, 2);
        word("b1w2", 8'h22, 1'b0, 1'b1, 3);
        word("b1w3", 8'h11, 1'b0, 1'b0, 3);
        word("b1w4", 8'h22, 1'b1, 1'b1, 3);
        finish_burst("b1", 8'h66);

        // len=3, first=1, sum wraps
        mem[0] = 8'hF0;
        mem[1] = 8'h20;
        start_burst(4'd3, 1'b1);
        word("b2w1", 8'h20, 1'b0, 1'b1, 2);
        word("b2w2", 8'hF0, 1'b0, 1'b0, 3);
        word("b2w3", 8'h20, 1'b1, 1'b1, 3);
        finish_burst("b2", 8'h30);

        // len=1 with ready low for 5 cycles
        bus.io_out_ready = 1'b0;
        start_burst(4'd1, 1'b0);
        word("b3w1", 8'hF0, 1'b1, 1'b0, 2);
        for (int i = 1; i < 5; i++) begin
            @(negedge clk);
            chk("b3 hold valid", bus.io_out_valid, 1'b1);
            chk("b3 hold bits",  bus.io_out_bits, 8'hF0);
            chk("b3 hold last",  bus.io_out_last, 1'b1);
            chk("b3 hold done",  bus.io_done, 1'b0);
        end
        bus.io_out_ready = 1'b1;
        finish_burst("b3", 8'hF0);

        // len=0 means 16 words
        mem[0] = 8'h01;
        mem[1] = 8'h02;
        start_burst(4'd0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            word("b4w", (i % 2 == 1) ? 8'h02 : 8'h01, (i == 15), (i % 2 == 1),
                 (i == 0) ? 2 : 3);
        end
        finish_burst("b4", 8'h18);

        // Reset during the 2nd word of a len=4 burst, then start on release
        mem[0] = 8'h11;
        mem[1] = 8'h22;
        start_burst(4'd4, 1'b0);
        word("b5w1", 8'h11, 1'b0, 1'b0, 2);
        word("b5w2", 8'h22, 1'b0, 1'b1, 3);
        reset = 1'b0;
        #1;
        chk("b5 async busy",  bus.io_busy, 1'b0);
        chk("b5 async valid", bus.io_out_valid, 1'b0);
        chk("b5 async bits",  bus.io_out_bits, 8'h00);
        chk("b5 async sum",   bus.io_sum, 8'h00);
        chk("b5 async radd",  bus.io_RADD, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("b5 no done", bus.io_done, 1'b0);
        end
        @(negedge clk);
        reset        = 1'b1;
        bus.io_start = 1'b1;
        bus.io_len   = 4'd2;
        bus.io_first = 1'b1;
        @(negedge clk);
        bus.io_start = 1'b0;
        chk("b6 start at release", bus.io_busy, 1'b1);
        word("b6w1", 8'h22, 1'b0, 1'b1, 2);
        word("b6w2", 8'h11, 1'b1, 1'b0, 3);
        finish_burst("b6", 8'h33);

        // io_start during OUT and DONE is ignored
        start_burst(4'd3, 1'b0);
        word("b7w1", 8'h11, 1'b0, 1'b0, 2);
        bus.io_start = 1'b1;
        bus.io_len   = 4'd1;
        @(negedge clk);
        bus.io_start = 1'b0;
        chk("b7 busy after start in OUT", bus.io_busy, 1'b1);
        word("b7w2", 8'h22, 1'b0, 1'b1, 2);
        word("b7w3", 8'h11, 1'b1, 1'b0, 3);
        @(negedge clk);
        bus.io_start = 1'b1;
        chk("b7 done", bus.io_done, 1'b1);
        chk("b7 sum",  bus.io_sum, 8'h44);
        @(negedge clk);
        bus.io_start = 1'b0;
        chk("b7 idle after done", bus.io_busy, 1'b0);
        @(negedge clk);
        chk("b7 start in DONE ignored", bus.io_busy, 1'b0);

        // READ_LAT=0 instance: one word per 2 cycles
        @(negedge clk);
        bus0.io_start = 1'b1;
        bus0.io_len   = 4'd2;
        bus0.io_first = 1'b0;
        @(negedge clk);
        bus0.io_start = 1'b0;
        chk("l0 addr valid", bus0.io_out_valid, 1'b0);
        chk("l0 addr busy",  bus0.io_busy, 1'b1);
        @(negedge clk);
        chk("l0 w1 valid", bus0.io_out_valid, 1'b1);
        chk("l0 w1 bits",  bus0.io_out_bits, 8'h11);
        chk("l0 w1 last",  bus0.io_out_last, 1'b0);
        @(negedge clk);
        chk("l0 gap valid", bus0.io_out_valid, 1'b0);
        @(negedge clk);
        chk("l0 w2 valid", bus0.io_out_valid, 1'b1);
        chk("l0 w2 bits",  bus0.io_out_bits, 8'h22);
        chk("l0 w2 last",  bus0.io_out_last, 1'b1);
        @(negedge clk);
        chk("l0 done", bus0.io_done, 1'b1);
        chk("l0 sum",  bus0.io_sum, 8'h33);
        @(negedge clk);
        chk("l0 idle", bus0.io_busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nram_read_seq.md
NRAM_READ_SEQ -- requirements
Module: nram_read_seq

Interface
REQ-001 SHALL have parameter W, default 8: width of the storage data word and of the output stream.
REQ-002 SHALL have parameter READ_LAT, default 1: cycles from io_RADD change to valid io_Q; legal values are 0 and 1.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have port io_start, input, 1 bit: single-cycle request to begin a read burst.
REQ-006 SHALL have port io_len, input, 4 bits: number of words in the burst, sampled with io_start; 0 means 16.
REQ-007 SHALL have port io_first, input, 1 bit: first address of the burst, sampled with io_start.
REQ-008 SHALL have port io_RADD, output, 1 bit: read address driven to the upstream 2-entry storage stage.
REQ-009 SHALL have port io_Q, input, W bits: read data returned by the storage stage.
REQ-010 SHALL have port io_out_valid, output, 1 bit: an output word is presented.
REQ-011 SHALL have port io_out_ready, input, 1 bit: the consumer accepts the word this cycle.
REQ-012 SHALL have port io_out_bits, output, W bits: output word.
REQ-013 SHALL have port io_out_last, output, 1 bit: the presented word is the last of the burst.
REQ-014 SHALL have port io_busy, output, 1 bit: the FSM is not in IDLE.
REQ-015 SHALL have port io_done, output, 1 bit: one-cycle pulse after the last word is accepted.
REQ-016 SHALL have port io_sum, output, W bits: wrapping modulo-2^W sum of the words accepted in the current or most recent burst.

Function
REQ-017 SHALL implement the FSM states IDLE, ADDR, WAIT, OUT and DONE.
REQ-018 IDLE with io_start=1 SHALL latch the remaining count (io_len, 0 -> 16), latch the address (io_first), clear io_sum, and go to ADDR.
REQ-019 ADDR SHALL drive the latched address on io_RADD, then go to WAIT if READ_LAT=1, or capture io_Q that same cycle and go to OUT if READ_LAT=0.
REQ-020 WAIT SHALL capture io_Q into the output register and go to OUT.
REQ-021 io_RADD SHALL hold its value across ADDR, WAIT and OUT, and SHALL hold its last value in IDLE and DONE.
REQ-022 OUT SHALL assert io_out_valid, and io_out_bits SHALL remain stable while io_out_valid=1 and io_out_ready=0.
REQ-023 In OUT, on io_out_ready=1: io_sum += io_out_bits, count -= 1, address toggles (wrap 1 -> 0), and the FSM goes to DONE if count was 1, otherwise to ADDR.
REQ-024 io_out_last SHALL equal (count == 1) while in OUT, and 0 otherwise.
REQ-025 DONE SHALL assert io_done for exactly one cycle and then return to IDLE.
REQ-026 io_start SHALL be ignored in every state except IDLE, including DONE.
REQ-027 Throughput SHALL be one word per 2 cycles for READ_LAT=0 and per 3 cycles for READ_LAT=1, with io_out_ready held at 1.
REQ-028 The count SHALL be held in 5 bits; io_sum SHALL wrap without a carry output.

Reset
REQ-029 reset=0 SHALL immediately, without a clock, force: state IDLE, io_RADD=0, io_out_valid=0, io_out_bits=0, io_out_last=0, io_busy=0, io_done=0, io_sum=0, count=0.
REQ-030 Reset asserted in the middle of a burst SHALL abort it; no io_done pulse SHALL follow, and the first clock after release SHALL observe IDLE.
REQ-031 io_start asserted in the same cycle that reset is released SHALL be accepted on that clock edge.

Verification
REQ-032 Store D0=0x11, D1=0x22; start with len=4, first=0, ready=1 -> out 0x11,0x22,0x11,0x22; last on the 4th word; done one cycle later; sum=0x66.
REQ-033 Store D0=0xF0, D1=0x20; start with len=3, first=1 -> out 0x20,0xF0,0x20; sum=0x30 (wrapped).
REQ-034 len=1 with ready low for 5 cycles -> io_out_valid held 5 cycles with stable bits and last=1; done exactly one cycle after the accept.
REQ-035 len=0 -> exactly 16 words are output, last=1 only on the 16th, and io_RADD alternates each word.
REQ-036 reset pulsed low during the 2nd word of a len=4 burst -> all outputs 0 asynchronously; no done pulse; a new start after release runs normally.
REQ-037 io_start pulsed during OUT and during DONE -> ignored; busy stays high until the burst ends and the burst length is unchanged.
